// File: rtl/alloc_scheduler.sv
// Purpose : arbitrates read/write channel alloc and free requests onto a single
//           shared ID allocator, one operation per cycle, and tracks per-channel
//           outstanding counts.
// Latency : zero; grants, accepts and returned IDs are combinational.
// Backpressure: alloc_ready follows alloc_gnt for the chosen channel. A channel
//           at its outstanding limit is not eligible. The losing class or
//           channel waits and must hold valid and payload.
//
// Optional build macro: ALLOC_SCHED_RR_EN. When it is defined, each class uses
// round-robin selection between rd and wr. When it is not defined, rd has fixed
// priority over wr.
//
// Ports:
//   clk, rst              rising-edge clock; synchronous active-low reset
//   rd_/wr_alloc_*        channel alloc handshake (valid, orig_id, ready, unique_id)
//   rd_/wr_free_*         channel free handshake (valid, free_id, ready, restored_id)
//   alloc_req/in_orig_id  allocator alloc port, request side
//   alloc_gnt/unique_id   allocator alloc port, response side
//   id_matrix_full        allocator is full
//   free_req/unique_id_to_free/restored_id   allocator free port
//   rd_cnt, wr_cnt        outstanding IDs per channel
//   free_err              sticky flag, set by a free on a channel that has nothing outstanding
module alloc_scheduler #(
  parameter int ID_WIDTH        = 16,
  parameter int MAX_OUTSTANDING = 16,
  parameter int RD_MAX_OUT      = 8,
  parameter int WR_MAX_OUT      = 8,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_alloc_valid,
  input  logic [ID_WIDTH-1:0] rd_orig_id,
  output logic                rd_alloc_ready,
  output logic [ID_WIDTH-1:0] rd_unique_id,
  input  logic                wr_alloc_valid,
  input  logic [ID_WIDTH-1:0] wr_orig_id,
  output logic                wr_alloc_ready,
  output logic [ID_WIDTH-1:0] wr_unique_id,
  input  logic                rd_free_valid,
  input  logic [ID_WIDTH-1:0] rd_free_id,
  output logic                rd_free_ready,
  output logic [ID_WIDTH-1:0] rd_restored_id,
  input  logic                wr_free_valid,
  input  logic [ID_WIDTH-1:0] wr_free_id,
  output logic                wr_free_ready,
  output logic [ID_WIDTH-1:0] wr_restored_id,
  output logic                alloc_req,
  output logic [ID_WIDTH-1:0] in_orig_id,
  input  logic                alloc_gnt,
  input  logic [ID_WIDTH-1:0] unique_id,
  input  logic                id_matrix_full,
  output logic                free_req,
  output logic [ID_WIDTH-1:0] unique_id_to_free,
  input  logic [ID_WIDTH-1:0] restored_id,
  output logic [CNT_W-1:0]    rd_cnt,
  output logic [CNT_W-1:0]    wr_cnt,
  output logic                free_err
);

  localparam logic [CNT_W-1:0] RD_LIM  = CNT_W'(RD_MAX_OUT);
  localparam logic [CNT_W-1:0] WR_LIM  = CNT_W'(WR_MAX_OUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic             free_err_q, free_err_d;
  logic             last_alloc_q, last_alloc_d;

  logic rd_alloc_elig, wr_alloc_elig, any_alloc, any_free, sel_free;
  logic alloc_pick_wr, free_pick_wr;

  assign rd_alloc_elig = rd_alloc_valid && (rd_cnt_q < RD_LIM);
  assign wr_alloc_elig = wr_alloc_valid && (wr_cnt_q < WR_LIM);
  assign any_alloc     = rd_alloc_elig || wr_alloc_elig;
  assign any_free      = rd_free_valid || wr_free_valid;
  // Free wins a contested cycle after an alloc, or whenever the allocator is full.
  // This alternation keeps either class from starving the other.
  assign sel_free      = any_free && (!any_alloc || id_matrix_full || last_alloc_q);

`ifdef ALLOC_SCHED_RR_EN
  // Each pointer names the channel that wins a tie in its class (0 = rd, 1 = wr).
  logic ptr_alloc_q, ptr_alloc_d, ptr_free_q, ptr_free_d;
  assign alloc_pick_wr = wr_alloc_elig && (!rd_alloc_elig || ptr_alloc_q);
  assign free_pick_wr  = wr_free_valid && (!rd_free_valid || ptr_free_q);
`else
  assign alloc_pick_wr = !rd_alloc_elig;
  assign free_pick_wr  = !rd_free_valid;
`endif

  // The allocator's response is routed to both channels. Each copy is only
  // meaningful while the ready signal of that channel is high.
  assign rd_unique_id   = unique_id;
  assign wr_unique_id   = unique_id;
  assign rd_restored_id = restored_id;
  assign wr_restored_id = restored_id;
  assign rd_cnt         = rd_cnt_q;
  assign wr_cnt         = wr_cnt_q;
  assign free_err       = free_err_q;

  always_comb begin
    rd_alloc_ready    = 1'b0;
    wr_alloc_ready    = 1'b0;
    rd_free_ready     = 1'b0;
    wr_free_ready     = 1'b0;
    alloc_req         = 1'b0;
    in_orig_id        = '0;
    free_req          = 1'b0;
    unique_id_to_free = '0;
    rd_cnt_d          = rd_cnt_q;
    wr_cnt_d          = wr_cnt_q;
    free_err_d        = free_err_q;
    last_alloc_d      = last_alloc_q;
`ifdef ALLOC_SCHED_RR_EN
    ptr_alloc_d       = ptr_alloc_q;
    ptr_free_d        = ptr_free_q;
`endif
    if (!rst) begin
      // All handshakes are held low while reset is asserted.
    end else if (sel_free) begin
`ifdef ALLOC_SCHED_RR_EN
      ptr_free_d = !free_pick_wr;
`endif
      if (free_pick_wr) begin
        wr_free_ready = 1'b1;
        if (wr_cnt_q == '0) begin
          // Underflow: consume the free without sending it to the allocator.
          free_err_d = 1'b1;
        end else begin
          free_req          = 1'b1;
          unique_id_to_free = wr_free_id;
          wr_cnt_d          = wr_cnt_q - CNT_ONE;
          last_alloc_d      = 1'b0;
        end
      end else begin
        rd_free_ready = 1'b1;
        if (rd_cnt_q == '0) begin
          free_err_d = 1'b1;
        end else begin
          free_req          = 1'b1;
          unique_id_to_free = rd_free_id;
          rd_cnt_d          = rd_cnt_q - CNT_ONE;
          last_alloc_d      = 1'b0;
        end
      end
    end else if (any_alloc) begin
      alloc_req  = 1'b1;
      in_orig_id = alloc_pick_wr ? wr_orig_id : rd_orig_id;
      if (alloc_pick_wr) wr_alloc_ready = alloc_gnt;
      else               rd_alloc_ready = alloc_gnt;
      // A request that is not granted leaves all bookkeeping unchanged.
      if (alloc_gnt) begin
        last_alloc_d = 1'b1;
        if (alloc_pick_wr) wr_cnt_d = wr_cnt_q + CNT_ONE;
        else               rd_cnt_d = rd_cnt_q + CNT_ONE;
`ifdef ALLOC_SCHED_RR_EN
        ptr_alloc_d = !alloc_pick_wr;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      free_err_q   <= 1'b0;
      last_alloc_q <= 1'b0;
`ifdef ALLOC_SCHED_RR_EN
      ptr_alloc_q  <= 1'b0;
      ptr_free_q   <= 1'b0;
`endif
    end else begin
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      free_err_q   <= free_err_d;
      last_alloc_q <= last_alloc_d;
`ifdef ALLOC_SCHED_RR_EN
      ptr_alloc_q  <= ptr_alloc_d;
      ptr_free_q   <= ptr_free_d;
`endif
    end
  end

endmodule
